// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package boot_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  // Common IMEM size of the fetch stage; the loader depth follows it.
  localparam int IMEM_SIZE_WORDS    = 64;
  localparam int DEFAULT_IMEM_WORDS = IMEM_SIZE_WORDS;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
    S_WRITE,
    S_CSUM,
    S_RELEASE,
    S_RUN,
    S_ERR
  } boot_state_e;

  // Control outputs that are pure decodes of the state.
  typedef struct packed {
    logic byte_ready;
    logic fetch_rst;
    logic fetch_we;
    logic pc_sel;
    logic core_hold;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  function automatic ctrl_t decode_state(boot_state_e s);
    ctrl_t c;
    c.byte_ready = (s inside {S_HDR_HI, S_HDR_LO, S_LOAD, S_CSUM});
    c.fetch_rst  = (s inside {S_IDLE, S_RELEASE, S_ERR});
    c.fetch_we   = (s == S_WRITE);
    c.pc_sel     = (s != S_RUN);
    c.core_hold  = (s != S_RUN);
    c.busy       = (s inside {S_HDR_HI, S_HDR_LO, S_LOAD, S_WRITE, S_CSUM, S_RELEASE});
    c.done       = (s == S_RUN);
    c.err        = (s == S_ERR);
    return c;
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream valid/ready channel feeding the boot controller.
interface imem_boot_ctrl_if;
  import boot_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_boot_ctrl_word_asm.sv
// Big-endian word assembler: shifts accepted bytes into a 32-bit word,
// flags the 4th byte and keeps the running XOR of the load.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              acc_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_next_o,
  output logic              word_done_o,
  output logic [BYTE_W-1:0] xor_o
);

  logic [WORD_W-1:0] sr_q;
  logic [1:0]        cnt_q;
  logic [BYTE_W-1:0] xor_q;

  // Word as it will look once the current byte is shifted in.
  assign word_next_o = {sr_q[WORD_W-BYTE_W-1:0], byte_i};
  assign word_done_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign xor_o       = xor_q;

  // Shift register, byte counter and checksum; cleared at the start of each load.
  always_ff @(posedge CLK) begin
    if (!RST || clr_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      xor_q <= '0;
    end else begin
      if (shift_i) begin
        sr_q  <= word_next_o;
        cnt_q <= cnt_q + 2'd1;
      end
      if (acc_i) begin
        xor_q <= xor_q ^ byte_i;
      end
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader for the fetch stage: parses a length-prefixed byte stream,
// writes big-endian words into IMEM, verifies the XOR checksum and then
// resets the fetch PC and releases the core.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  imem_boot_ctrl_if.slave   bs,
  output logic              fetch_rst,
  output logic              fetch_we,
  output logic [WORD_W-1:0] fetch_wins,
  output logic [WORD_W-1:0] fetch_newpc,
  output logic              pc_sel,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

  boot_state_e       state_q, state_d;
  ctrl_t             ctrl_q;
  logic [15:0]       n_q, n_d, k_q, k_d, n_full, k_inc;
  logic [WORD_W-1:0] wins_q, newpc_q, word_next;
  logic [BYTE_W-1:0] xor_run;
  logic              accept, load_start, shift_en, acc_en, word_done;

  assign accept   = bs.byte_valid && ctrl_q.byte_ready;
  assign n_full   = {n_q[15:8], bs.byte_data};
  assign k_inc    = k_q + 16'd1;
  assign shift_en = accept && (state_q == S_LOAD);
  assign acc_en   = accept && (state_q inside {S_HDR_HI, S_HDR_LO, S_LOAD});

  boot_word_asm u_asm (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (load_start),
    .shift_i    (shift_en),
    .acc_i      (acc_en),
    .byte_i     (bs.byte_data),
    .word_next_o(word_next),
    .word_done_o(word_done),
    .xor_o      (xor_run)
  );

  // Next-state, word-count and word-index logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    k_d        = k_q;
    load_start = 1'b0;
    case (state_q)
      S_IDLE, S_ERR, S_RUN: begin
        if (start) begin
          state_d    = S_HDR_HI;
          k_d        = '0;
          load_start = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d     = {bs.byte_data, n_q[7:0]};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d = n_full;
          k_d = '0;
          if ({1'b0, n_full} > MAX_N) state_d = S_ERR;
          else if (n_full == 16'd0)   state_d = S_CSUM;
          else                        state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (word_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        k_d     = k_inc;
        state_d = (k_inc == n_q) ? S_CSUM : S_LOAD;
      end
      S_CSUM: begin
        if (accept) state_d = (bs.byte_data == xor_run) ? S_RELEASE : S_ERR;
      end
      S_RELEASE: state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, counters and registered output decodes (outputs track the new state).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      ctrl_q  <= decode_state(S_IDLE);
      wins_q  <= '0;
      newpc_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      ctrl_q  <= decode_state(state_d);
      if (state_d == S_WRITE) wins_q <= word_next;
      newpc_q <= (state_d inside {S_LOAD, S_WRITE}) ? {14'b0, k_d, 2'b00} : '0;
    end
  end

  assign bs.byte_ready = ctrl_q.byte_ready;
  assign fetch_rst     = ctrl_q.fetch_rst;
  assign fetch_we      = ctrl_q.fetch_we;
  assign pc_sel        = ctrl_q.pc_sel;
  assign core_hold     = ctrl_q.core_hold;
  assign busy          = ctrl_q.busy;
  assign done          = ctrl_q.done;
  assign err           = ctrl_q.err;
  assign fetch_wins    = wins_q;
  assign fetch_newpc   = newpc_q;
  assign words_loaded  = k_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed and random loads compared
// against a stream-level model of the boot protocol.
module tb_imem_boot_ctrl;

  localparam int IMEM_W = 64;
  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        fetch_rst, fetch_we, pc_sel, core_hold, busy, done, err;
  logic [31:0] fetch_wins, fetch_newpc;
  logic [15:0] words_loaded;

  imem_boot_ctrl_if bs();

  imem_boot_ctrl #(.IMEM_WORDS(IMEM_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .bs(bs),
    .fetch_rst(fetch_rst), .fetch_we(fetch_we), .fetch_wins(fetch_wins),
    .fetch_newpc(fetch_newpc), .pc_sel(pc_sel), .core_hold(core_hold),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rel_cnt = 0;
  logic [63:0] obs_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every IMEM write as {pc, word} and every release pulse.
  always @(negedge CLK) begin
    if (fetch_we === 1'b1) obs_q.push_back({fetch_newpc, fetch_wins});
    if (fetch_rst === 1'b1 && busy === 1'b1) rel_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int budget;
    if (gap == 1) begin
      bs.byte_valid = 1'b0;
      @(posedge CLK); #1;
    end else if (gap == 2) begin
      bs.byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    budget = 20;
    while (bs.byte_ready !== 1'b1 && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end
    ok = (budget > 0);
    if (ok) begin @(posedge CLK); #1; end
    bs.byte_valid = 1'b0;
  endtask

  task automatic make_stream(input int n, input bit corrupt, output bq_t s);
    logic [7:0] x, b;
    s.delete();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n > IMEM_W) return;
    x = s[0] ^ s[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s.push_back(b);
      x ^= b;
    end
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    s.push_back(x);
  endtask

  // Drive one load from the current state and compare against the stream model.
  task automatic run_load(input string tag, input bq_t s, input int gap);
    int          n, t0, base, rel0, budget, nbytes;
    logic [7:0]  x;
    bit          exp_err, ok;
    logic [63:0] exp_w[$];

    n = int'({s[0], s[1]});
    x = s[0] ^ s[1];
    if (n > IMEM_W) begin
      exp_err = 1'b1;
      nbytes  = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({32'(4 * i), s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
        x ^= s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      end
      nbytes  = 2 + 4 * n + 1;
      exp_err = (s[nbytes-1] != x);
    end

    base = obs_q.size();
    rel0 = rel_cnt;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    t0 = cyc;
    check($sformatf("%s.busy_at_start", tag), 64'(busy), 64'(1));

    ok = 1'b1;
    for (int i = 0; i < nbytes && ok; i++) send_byte(s[i], gap, ok);
    check($sformatf("%s.bytes_accepted", tag), 64'(ok), 64'(1));

    budget = 30;
    while (done !== 1'b1 && err !== 1'b1 && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end

    check($sformatf("%s.err", tag), 64'(err), 64'(exp_err));
    check($sformatf("%s.done", tag), 64'(done), 64'(!exp_err));
    check($sformatf("%s.core_hold", tag), 64'(core_hold), 64'(exp_err));
    check($sformatf("%s.pc_sel", tag), 64'(pc_sel), 64'(exp_err));
    check($sformatf("%s.fetch_rst", tag), 64'(fetch_rst), 64'(exp_err));
    check($sformatf("%s.busy", tag), 64'(busy), 64'(0));
    check($sformatf("%s.byte_ready", tag), 64'(bs.byte_ready), 64'(0));
    check($sformatf("%s.words_loaded", tag), 64'(words_loaded), 64'((n > IMEM_W) ? 0 : n));
    check($sformatf("%s.release_pulses", tag), 64'(rel_cnt - rel0), 64'(!exp_err));
    if (gap == 0 && !exp_err)
      check($sformatf("%s.load_cycles", tag), 64'(cyc - t0), 64'(2 + 5 * n + 2));
    if (n > IMEM_W)
      check($sformatf("%s.hdr_err_cycles", tag), 64'(cyc - t0), 64'(2));

    repeat (3) @(posedge CLK);
    #1;
    check($sformatf("%s.write_count", tag), 64'(obs_q.size() - base), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("%s.write%0d", tag, i), obs_q[base+i], exp_w[i]);
    check($sformatf("%s.state_held", tag), 64'({err, done}), 64'({exp_err, !exp_err}));
    $display("load %s: N=%0d gap=%0d err=%0b words_loaded=%0d", tag, n, gap, err, words_loaded);
  endtask

  initial begin
    bq_t s, s2;
    bit  ok;
    int  b0, n;
    bit  corrupt;
    int  gap;

    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;

    // Reset held for two cycles.
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.byte_ready", 64'(bs.byte_ready), 64'(0));
    check("rst.fetch_we", 64'(fetch_we), 64'(0));
    check("rst.fetch_wins", 64'(fetch_wins), 64'(0));
    check("rst.fetch_newpc", 64'(fetch_newpc), 64'(0));
    check("rst.pc_sel", 64'(pc_sel), 64'(1));
    check("rst.fetch_rst", 64'(fetch_rst), 64'(1));
    check("rst.core_hold", 64'(core_hold), 64'(1));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.err", 64'(err), 64'(0));
    check("rst.words_loaded", 64'(words_loaded), 64'(0));
    RST = 1'b1;
    @(posedge CLK); #1;
    $display("reset checked");

    // Reference two-word image.
    s = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
    b0 = obs_q.size();
    run_load("fixed", s, 0);
    check("fixed.word0", obs_q[b0], {32'd0, 32'h2008_0005});
    check("fixed.word1", obs_q[b0+1], {32'd4, 32'hAC08_0000});

    // Bad checksum.
    s2 = s;
    s2[10] = 8'h8C;
    run_load("bad_csum", s2, 0);

    // Oversize header.
    s2 = {8'h00, 8'h41};
    run_load("oversize", s2, 0);

    // Valid toggling every other cycle.
    b0 = obs_q.size();
    run_load("toggle", s, 1);
    check("toggle.word0", obs_q[b0], {32'd0, 32'h2008_0005});
    check("toggle.word1", obs_q[b0+1], {32'd4, 32'hAC08_0000});

    // Reset right after the first WRITE.
    make_stream(2, 1'b0, s2);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6 && ok; i++) send_byte(s2[i], 0, ok);
    check("mid.first_write", 64'(fetch_we), 64'(1));
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    check("mid.busy", 64'(busy), 64'(0));
    check("mid.fetch_rst", 64'(fetch_rst), 64'(1));
    check("mid.fetch_we", 64'(fetch_we), 64'(0));
    check("mid.done", 64'(done), 64'(0));
    check("mid.words_loaded", 64'(words_loaded), 64'(0));
    check("mid.fetch_newpc", 64'(fetch_newpc), 64'(0));
    $display("mid-load reset checked");
    run_load("after_reset", s2, 0);

    // Empty image.
    s2 = {8'h00, 8'h00, 8'h00};
    run_load("empty", s2, 0);

    // Boundary sizes.
    make_stream(IMEM_W, 1'b0, s2);
    run_load("max_words", s2, 0);
    make_stream(IMEM_W + 1, 1'b0, s2);
    run_load("max_plus1", s2, 0);

    // Random loads.
    for (int it = 0; it < 8; it++) begin
      n       = $urandom_range(0, 6);
      corrupt = ($urandom_range(0, 3) == 0);
      gap     = $urandom_range(0, 2);
      make_stream(n, corrupt, s2);
      run_load($sformatf("rand%0d", it), s2, gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot loader and sequencer for the instruction-fetch stage. It receives a byte stream (valid/ready), assembles big-endian 32-bit instruction words and writes them into the fetch stage's instruction memory. It does this by owning the fetch stage's `newPC`, `WE`, `W_Ins` and reset inputs, while holding the rest of the core. After a checksum-verified load it resets the fetch PC to 0 and releases the core to run.

## Interface
Parameters:
- `IMEM_WORDS`, default 64: instruction memory depth in words. Must match the fetch stage's IMEM size.

Ports:
- `CLK`, in, 1: clock.
- `RST`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a load. Sampled in IDLE, ERR and RUN; ignored in all other states.
- `byte_valid`, in, 1: input stream byte valid.
- `byte_data`, in, 8: input stream byte.
- `byte_ready`, out, 1: controller accepts the byte this cycle.
- `fetch_rst`, out, 1: active-high reset to the fetch stage.
- `fetch_we`, out, 1: IMEM write enable to the fetch stage.
- `fetch_wins`, out, 32: IMEM write data.
- `fetch_newpc`, out, 32: PC value driven while `pc_sel` = 1.
- `pc_sel`, out, 1: 1 = the fetch stage's `newPC` comes from `fetch_newpc`; 0 = from the core.
- `core_hold`, out, 1: freezes register-file and data-memory writes in the core.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: core running on a verified image.
- `err`, out, 1: the last load failed.
- `words_loaded`, out, 16: count of words written in the current or last load.

## Operation
- **Stream format:** `N_hi`, `N_lo` (16-bit word count), then N×4 bytes (big-endian words), then `csum`. `csum` must equal the XOR of all preceding bytes of the load, header included.
- **Byte accept:** a byte is accepted on a cycle with `byte_valid` && `byte_ready`. `byte_ready` = 1 only in HDR_HI, HDR_LO, LOAD and CSUM.
- **States:**
  - IDLE: `start` → HDR_HI.
  - HDR_HI: on accept, latch the count high byte → HDR_LO.
  - HDR_LO: on accept, latch the count low byte. Then: N > `IMEM_WORDS` → ERR; N = 0 → CSUM; otherwise set k = 0 and go to LOAD.
  - LOAD: `fetch_newpc` = 4·k. Shift in bytes; on the 4th accepted byte → WRITE.
  - WRITE: exactly one cycle with `fetch_we` = 1, `fetch_wins` = assembled word and `fetch_newpc` = 4·k. Then k++ and `words_loaded`++. If k = N → CSUM, else → LOAD.
  - CSUM: on accept, compare the byte with the running XOR. Match → RELEASE; mismatch → ERR.
  - RELEASE: one cycle with `fetch_rst` = 1, which resets the fetch PC to 0 → RUN.
  - RUN: `start` → HDR_HI (reload). Clear `words_loaded` and the XOR.
  - ERR: `start` → HDR_HI.
- **Output decode:**
  - `fetch_rst` = 1 in IDLE, RELEASE and ERR; 0 elsewhere.
  - `core_hold` = 1 in every state except RUN.
  - `pc_sel` = 0 only in RUN.
  - `busy` = 1 in HDR_HI through RELEASE.
  - `done` = 1 in RUN.
  - `err` = 1 in ERR.
  - `fetch_we` = 1 only in WRITE.
- **Arithmetic:** k is 16-bit; `fetch_newpc` = {14'b0, k, 2'b00}. The running XOR is 8-bit and covers every accepted byte before `csum`.
- **Reset:** `RST` = 0 at any clock edge, including mid-load, forces IDLE with all outputs at reset values. IMEM contents are left as written; a partial image is never released to RUN.

## Timing
- **Reset values:**
  - state IDLE.
  - `byte_ready` 0, `fetch_we` 0, `fetch_wins` 0, `fetch_newpc` 0.
  - `pc_sel` 1, `fetch_rst` 1, `core_hold` 1.
  - `busy` 0, `done` 0, `err` 0, `words_loaded` 0.
- All outputs are registered state decodes; they change only on `CLK` rising edges.
- **Address stability:** `fetch_newpc` = 4·k is stable for at least 4 cycles before WRITE, so the fetch PC equals 4·k at the write edge.
- **Minimum load time:** 2 + 5N + 1 + 1 cycles from the HDR_HI entry to RUN, with `byte_valid` held high. Gaps in `byte_valid` only stretch the wait states.
- `byte_ready` = 0 in the WRITE cycle, so no byte is lost or duplicated.

## Structure
- **Package `boot_pkg`:**
  - state enum (IDLE, HDR_HI, HDR_LO, LOAD, WRITE, CSUM, RELEASE, RUN, ERR).
  - byte/word width constants.
  - the default `IMEM_WORDS`, tied to the common IMEM size parameter.
- **Sub-module `boot_word_asm`:** 4-byte big-endian shift register with a byte counter and a word-complete flag. It also keeps the running XOR.
- **Top level:** FSM, k/`words_loaded` counters and output decode.

## Test plan
- Hold `RST` = 0 for 2 cycles → every output at its reset value.
- Load 2 words with stream 00 02 20 08 00 05 AC 08 00 00 8B →
  - WRITE at PC 0 with 0x20080005, then WRITE at PC 4 with 0xAC080000;
  - one RELEASE cycle with `fetch_rst` = 1;
  - then `done` = 1, `pc_sel` = 0, `core_hold` = 0, `words_loaded` = 2.
- Same stream with `csum` = 8C → ERR: `err` = 1, `core_hold` = 1, no further `fetch_we`, `byte_ready` = 0.
- Header 00 41 (with `IMEM_WORDS` = 64) → ERR immediately after the second byte; no `fetch_we` ever asserted.
- `byte_valid` toggling every other cycle during the 2-word load → identical writes, exactly 2 `fetch_we` pulses.
- Reset mid-load and empty image:
  - `RST` = 0 after the first WRITE → IDLE; a subsequent full load reaches RUN.
  - Header 00 00 with `csum` 00 → RUN with `words_loaded` = 0.
